serial_link_phy_tx_mc: RTL and testbench

SERIAL_LINK_PHY_TX_MC -- requirements
Module: serial_link_phy_tx_mc

---
 rtl/serial_link_pkg.sv | 22 ++
 rtl/serial_link_phy_tx_lane_prbs.sv | 32 +++
 rtl/serial_link_phy_tx_mc.sv | 174 +++++++++++++++++
 tb/tb_serial_link_phy_tx_mc.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// Shared types and constants for the serial link PHY transmitter.
// The PRBS7 constants are only used when SERIAL_LINK_PHY_TX_PRBS_EN is defined.
package serial_link_pkg;

  localparam int unsigned ClkDivW = 6;
  typedef logic [ClkDivW-1:0] clk_div_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tx_state_e;

  // PRBS7 polynomial x^7 + x^6 + 1: feedback taps are register bits 6 and 5.
  localparam logic [6:0] Prbs7Seed = 7'h7F;
  localparam logic [6:0] Prbs7Taps = 7'h60;

  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], ^(s & Prbs7Taps)};
  endfunction

endpackage

// File: rtl/serial_link_phy_tx_lane_prbs.sv
// Single-lane PRBS7 generator; present only with SERIAL_LINK_PHY_TX_PRBS_EN.
// o_bit is the oldest register bit, so the lane emits the seed MSB first.
`ifdef SERIAL_LINK_PHY_TX_PRBS_EN
module serial_link_phy_tx_lane_prbs
  import serial_link_pkg::*;
#(
  parameter logic [6:0] Seed = Prbs7Seed
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_load,
  input  logic i_step,
  output logic o_bit
);

  logic [6:0] r_lfsr;

  // A step wins over a reload so the first RUN edge already advances.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= Seed;
    end else if (i_step) begin
      r_lfsr <= prbs7_step(r_lfsr);
    end else if (i_load) begin
      r_lfsr <= Seed;
    end
  end

  assign o_bit = r_lfsr[6];

endmodule
`endif

// File: rtl/serial_link_phy_tx_mc.sv
// Multi-channel source-synchronous TX PHY: forwards a divided clock and SDR/DDR lane data.
// Optional PRBS7 test pattern per lane when SERIAL_LINK_PHY_TX_PRBS_EN is defined.
module serial_link_phy_tx_mc
  import serial_link_pkg::*;
#(
  parameter int unsigned NumChannels = 2,
  parameter int unsigned NumLanes    = 8,
  parameter int unsigned MaxClkDiv   = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [$clog2(MaxClkDiv):0]        clk_div_i,
  input  logic [$clog2(MaxClkDiv):0]        clk_shift_start_i,
  input  logic [$clog2(MaxClkDiv):0]        clk_shift_end_i,
  input  logic                              ddr_en_i,
  input  logic [NumChannels-1:0]            chan_en_i,
  input  logic [NumChannels*2*NumLanes-1:0] data_i,
  input  logic                              valid_i,
`ifdef SERIAL_LINK_PHY_TX_PRBS_EN
  input  logic                              prbs_en_i,
`endif
  output logic                              ready_o,
  output logic                              busy_o,
  output logic [NumChannels-1:0]            ddr_clk_o,
  output logic [NumChannels*NumLanes-1:0]   ddr_o
);

  localparam int unsigned BeatW = NumChannels * 2 * NumLanes;
  localparam int unsigned LaneW = NumChannels * NumLanes;

  // Handshake: ready_o is a registered window that is high for the last counter
  // cycle of each RUN period; a beat transfers on the clk_i edge where
  // valid_i && ready_o, and it is driven on the lanes for the whole next period.

  function automatic clk_div_t clamp_div(input clk_div_t v);
    if (v < clk_div_t'(2)) return clk_div_t'(2);
    if (v > clk_div_t'(MaxClkDiv)) return clk_div_t'(MaxClkDiv);
    return {v[ClkDivW-1:1], 1'b0};
  endfunction

  tx_state_e        r_state, w_state_d;
  clk_div_t         r_cnt, w_cnt_d;
  clk_div_t         r_div, r_start, r_end;
  clk_div_t         w_div_d, w_start_d, w_end_d, w_half;
  logic             r_ddr_en, w_ddr_en_d;
  logic [NumChannels-1:0] r_chan_en, w_chan_en_d;
  logic [BeatW-1:0] r_beat, w_beat_d;
  logic [NumChannels-1:0] r_clk, w_clk_d;
  logic [LaneW-1:0] r_ddr, w_ddr_d;
  logic             r_ready, w_ready_d;
  logic             r_busy;
  logic             w_start_run, w_last, w_accept, w_active_d, w_hi, w_toggle;
  logic             w_prbs_d;
  logic [NumLanes-1:0] w_lanes;

`ifdef SERIAL_LINK_PHY_TX_PRBS_EN
  logic             r_prbs_en;
  logic             w_prbs_step;
  logic [LaneW-1:0] w_prbs_bits;

  assign w_prbs_d    = w_start_run ? prbs_en_i : r_prbs_en;
  assign w_prbs_step = w_prbs_d && w_active_d &&
                       ((w_cnt_d == '0) || (w_ddr_en_d && (w_cnt_d == w_half)));

  for (genvar g = 0; g < LaneW; g++) begin : g_prbs
    serial_link_phy_tx_lane_prbs #(
      .Seed(Prbs7Seed ^ 7'(g + 1))
    ) u_lane_prbs (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .i_load(r_state == IDLE),
      .i_step(w_prbs_step),
      .o_bit (w_prbs_bits[g])
    );
  end
`else
  assign w_prbs_d = 1'b0;
`endif

  // Config is captured only on the IDLE->RUN edge; the output flops already use it.
  always_comb begin
    w_start_run = (r_state == IDLE) && valid_i;
    w_div_d     = w_start_run ? clamp_div(clk_div_t'(clk_div_i)) : r_div;
    w_start_d   = w_start_run ? clk_div_t'(clk_shift_start_i) : r_start;
    w_end_d     = w_start_run ? clk_div_t'(clk_shift_end_i) : r_end;
    w_ddr_en_d  = w_start_run ? ddr_en_i : r_ddr_en;
    w_chan_en_d = w_start_run ? chan_en_i : r_chan_en;
    w_last      = (r_cnt == r_div - clk_div_t'(1));
    w_accept    = valid_i && r_ready;

    w_state_d = r_state;
    w_cnt_d   = '0;
    w_beat_d  = r_beat;
    unique case (r_state)
      IDLE: begin
        w_beat_d = '0;
        if (valid_i) w_state_d = RUN;
      end
      RUN: begin
        w_cnt_d = w_last ? '0 : r_cnt + clk_div_t'(1);
        if (w_last && !valid_i) w_state_d = DRAIN;
        if (w_accept) w_beat_d = data_i;
      end
      DRAIN: begin
        w_cnt_d = w_last ? '0 : r_cnt + clk_div_t'(1);
        if (w_last) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase

    w_active_d = (w_state_d != IDLE);
    w_half     = w_div_d >> 1;
    w_hi       = w_ddr_en_d && (w_cnt_d >= w_half);
    w_toggle   = (w_cnt_d == w_start_d) ^ (w_cnt_d == w_end_d);
    w_ready_d  = (w_state_d == RUN) && (w_cnt_d == w_div_d - clk_div_t'(1)) && !w_prbs_d;

    w_clk_d = '1;
    w_ddr_d = '0;
    w_lanes = '0;
    for (int c = 0; c < NumChannels; c++) begin
      w_lanes = w_hi ? w_beat_d[c*2*NumLanes+NumLanes +: NumLanes]
                     : w_beat_d[c*2*NumLanes +: NumLanes];
`ifdef SERIAL_LINK_PHY_TX_PRBS_EN
      if (w_prbs_d) w_lanes = w_prbs_bits[c*NumLanes +: NumLanes];
`endif
      if (w_active_d && w_chan_en_d[c]) begin
        w_clk_d[c]                   = r_clk[c] ^ w_toggle;
        w_ddr_d[c*NumLanes +: NumLanes] = w_lanes;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_div     <= clk_div_t'(2);
      r_start   <= '0;
      r_end     <= '0;
      r_ddr_en  <= 1'b0;
      r_chan_en <= '0;
      r_beat    <= '0;
      r_clk     <= '1;
      r_ddr     <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
`ifdef SERIAL_LINK_PHY_TX_PRBS_EN
      r_prbs_en <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_div     <= w_div_d;
      r_start   <= w_start_d;
      r_end     <= w_end_d;
      r_ddr_en  <= w_ddr_en_d;
      r_chan_en <= w_chan_en_d;
      r_beat    <= w_beat_d;
      r_clk     <= w_clk_d;
      r_ddr     <= w_ddr_d;
      r_ready   <= w_ready_d;
      r_busy    <= w_active_d;
`ifdef SERIAL_LINK_PHY_TX_PRBS_EN
      r_prbs_en <= w_prbs_d;
`endif
    end
  end

  assign ready_o   = r_ready;
  assign busy_o    = r_busy;
  assign ddr_clk_o = r_clk;
  assign ddr_o     = r_ddr;

endmodule

// File: tb/tb_serial_link_phy_tx_mc.sv
// Self-checking bench for serial_link_phy_tx_mc; PRBS section runs only when
// SERIAL_LINK_PHY_TX_PRBS_EN is defined.
module tb_serial_link_phy_tx_mc;

  localparam int NC = 2;
  localparam int NL = 8;
  localparam int MD = 32;
  localparam int DW = 6;
  localparam int BW = NC * 2 * NL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] clk_div, shift_start, shift_end;
  logic          ddr_en;
  logic [NC-1:0] chan_en;
  logic [BW-1:0] data;
  logic          valid;
  logic          ready, busy;
  logic [NC-1:0] ddr_clk;
  logic [NC*NL-1:0] ddr;
`ifdef SERIAL_LINK_PHY_TX_PRBS_EN
  logic          prbs_en = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*NL-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  serial_link_phy_tx_mc #(
    .NumChannels(NC),
    .NumLanes   (NL),
    .MaxClkDiv  (MD)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .clk_div_i        (clk_div),
    .clk_shift_start_i(shift_start),
    .clk_shift_end_i  (shift_end),
    .ddr_en_i         (ddr_en),
    .chan_en_i        (chan_en),
    .data_i           (data),
    .valid_i          (valid),
`ifdef SERIAL_LINK_PHY_TX_PRBS_EN
    .prbs_en_i        (prbs_en),
`endif
    .ready_o          (ready),
    .busy_o           (busy),
    .ddr_clk_o        (ddr_clk),
    .ddr_o            (ddr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int eff_div(input int v);
    if (v < 2) return 2;
    if (v > MD) return MD;
    return v - (v % 2);
  endfunction

  // Channel 1 carries the beat with its halves swapped so channels differ.
  function automatic logic [2*NL-1:0] chan_beat(input logic [2*NL-1:0] b, input int ch);
    if (ch == 0) return b;
    return {b[NL-1:0], b[2*NL-1:NL]};
  endfunction

  function automatic logic [BW-1:0] pack(input logic [2*NL-1:0] b);
    logic [BW-1:0] v;
    for (int ch = 0; ch < NC; ch++) v[ch*2*NL +: 2*NL] = chan_beat(b, ch);
    return v;
  endfunction

  // driver + reference: one transfer starting from IDLE (called at a negedge).
  task automatic run_xfer(input int div_in, input int st, input int en, input bit ddr_mode,
                          input logic [NC-1:0] cen, input int nbeats, input int rst_at);
    logic [2*NL-1:0] beats[$];
    logic [2*NL-1:0] eb, cb;
    logic [NC-1:0]   e_clk;
    logic [NC*NL-1:0] e_ddr;
    int d, p, c, total;
    bit in_busy;
    beats = exp_q;
    exp_q.delete();
    if (beats.size() == 0) for (int i = 0; i < nbeats; i++) beats.push_back(16'($urandom));
    nbeats = beats.size();
    d = eff_div(div_in);
    clk_div = DW'(div_in); shift_start = DW'(st); shift_end = DW'(en);
    ddr_en = ddr_mode; chan_en = cen; valid = 1'b1; data = BW'($urandom);
    @(posedge clk);
    total = (nbeats + 2) * d + 2;
    for (int t = 0; t < total; t++) begin
      @(negedge clk);
      p = t / d;
      c = t % d;
      if (p < nbeats) begin
        valid = 1'b1;
        data  = pack(beats[p]);
      end else if (p == nbeats + 1 && c != d - 1) begin
        valid = 1'($urandom_range(0, 1));
        data  = BW'($urandom);
      end else begin
        valid = 1'b0;
      end
      clk_div     = (t % 2 == 1) ? DW'(8) : DW'($urandom);
      shift_start = DW'($urandom);
      shift_end   = DW'($urandom);
      ddr_en      = 1'($urandom);
      chan_en     = NC'($urandom);

      in_busy = (p <= nbeats + 1);
      if (p == 0) eb = '0;
      else if (p <= nbeats) eb = beats[p-1];
      else eb = beats[nbeats-1];
      e_clk = '1;
      e_ddr = '0;
      if (in_busy) begin
        for (int ch = 0; ch < NC; ch++) begin
          if (cen[ch]) begin
            cb = chan_beat(eb, ch);
            e_clk[ch] = !(c >= st && c < en);
            e_ddr[ch*NL +: NL] = (ddr_mode && c >= d / 2) ? cb[2*NL-1:NL] : cb[NL-1:0];
          end
        end
      end
      check($sformatf("busy t=%0d", t), busy, in_busy);
      check($sformatf("ddr_clk t=%0d", t), ddr_clk, e_clk);
      check($sformatf("ddr t=%0d", t), ddr, e_ddr);
      if (valid) check($sformatf("ready t=%0d", t), ready, (p < nbeats) && (c == d - 1));

      if (t == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_ready", ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ddr_clk", ddr_clk, {NC{1'b1}});
        check("rst_ddr", ddr, '0);
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    int dv, d, st, en;
    valid = 1'b0; data = '0; clk_div = DW'(4); shift_start = '0; shift_end = '0;
    ddr_en = 1'b0; chan_en = '1;
    repeat (3) @(negedge clk);
    check("reset_ready", ready, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_ddr_clk", ddr_clk, {NC{1'b1}});
    check("reset_ddr", ddr, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);

    exp_q = '{16'hA53C, 16'h0FF0};
    run_xfer(4, 1, 3, 1'b1, 2'b11, 2, -1);
    exp_q = '{16'h0081};
    run_xfer(6, 0, 3, 1'b0, 2'b11, 1, -1);
    run_xfer(3, 0, 1, 1'b1, 2'b11, 3, -1);
    run_xfer(1, 0, 1, 1'b0, 2'b11, 2, -1);
    run_xfer(7, 1, 4, 1'b1, 2'b11, 2, -1);
    run_xfer(40, 5, 20, 1'b0, 2'b11, 1, -1);
    run_xfer(8, 2, 6, 1'b1, 2'b01, 3, -1);

    for (int k = 0; k < 4; k++) begin
      dv = $urandom_range(0, 40);
      d  = eff_div(dv);
      st = $urandom_range(0, d - 2);
      en = $urandom_range(st + 1, d - 1);
      run_xfer(dv, st, en, 1'($urandom), NC'($urandom_range(0, 3)), $urandom_range(1, 4), -1);
    end

    run_xfer(8, 1, 5, 1'b1, 2'b11, 3, 8 + 2);
    check("post_rst_busy", busy, 1'b0);
    run_xfer(4, 1, 3, 1'b1, 2'b11, 2, -1);

`ifdef SERIAL_LINK_PHY_TX_PRBS_EN
    begin
      logic       a[0:260];
      logic [6:0] seed;
      seed = 7'h7E;
      for (int i = 0; i < 7; i++) a[i] = seed[6-i];
      for (int i = 7; i <= 260; i++) a[i] = a[i-7] ^ a[i-6];
      prbs_en = 1'b1; clk_div = DW'(4); shift_start = DW'(1); shift_end = DW'(3);
      ddr_en = 1'b1; chan_en = 2'b11; valid = 1'b1;
      @(posedge clk);
      for (int h = 0; h < 254; h++) begin
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          if (k == 0) check($sformatf("prbs_lane0 h=%0d", h), ddr[0], a[h]);
          check($sformatf("prbs_ready h=%0d", h), ready, 1'b0);
        end
      end
      valid = 1'b0;
      prbs_en = 1'b0;
      repeat (12) @(negedge clk);
      check("prbs_end_busy", busy, 1'b0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
